inst_mem: RTL and testbench

INST_MEM -- requirements
Module: inst_mem

---
 rtl/inst_mem_pkg.sv | 21 ++
 rtl/inst_mem_if.sv | 29 ++
 rtl/inst_ram_1r1w.sv | 24 ++
 rtl/inst_mem.sv | 75 +++++++
 tb/tb_inst_mem.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/inst_mem_pkg.sv
// Shared definitions for the instruction memory: bus types, enable/reset levels, NOP word
// and the fetch-address legality rule.
package inst_mem_pkg;

    localparam int unsigned InstAddrBusW = 32;
    localparam int unsigned InstBusW     = 32;

    typedef logic [InstAddrBusW-1:0] inst_addr_bus_t;
    typedef logic [InstBusW-1:0]     inst_bus_t;

    localparam logic      ChipEnable  = 1'b1;
    localparam logic      ChipDisable = 1'b0;
    localparam logic      RstEnable   = 1'b0;
    localparam inst_bus_t Nop         = 32'h0;

    // A fetch is illegal when misaligned or beyond the 2**aw word array (no aliasing).
    function automatic logic fetch_err(inst_addr_bus_t a, int unsigned aw);
        return (a[1:0] != 2'b00) || ((a >> (aw + 2)) != '0);
    endfunction

endpackage

// File: rtl/inst_mem_if.sv
// Fetch/loader bus between the fetch stage (master) and the instruction memory (slave).
interface inst_mem_if #(
    parameter int unsigned AW = 8
);
    import inst_mem_pkg::*;

    logic           ce;
    inst_addr_bus_t addr;
    logic           stall;
    logic           ld_we;
    logic [AW-1:0]  ld_addr;
    inst_bus_t      ld_data;
    inst_bus_t      inst;
    inst_addr_bus_t inst_addr;
    logic           inst_valid;
    logic           addr_err;
    logic [31:0]    fetch_cnt;

    modport master (
        output ce, addr, stall, ld_we, ld_addr, ld_data,
        input  inst, inst_addr, inst_valid, addr_err, fetch_cnt
    );

    modport slave (
        input  ce, addr, stall, ld_we, ld_addr, ld_data,
        output inst, inst_addr, inst_valid, addr_err, fetch_cnt
    );

endinterface

// File: rtl/inst_ram_1r1w.sv
// Instruction storage: one synchronous write port, one combinational read port, no reset.
module inst_ram_1r1w #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inst_mem.sv
// Instruction memory with 1-cycle registered fetch, loader port with write-through bypass,
// address error flagging, stall hold and a delivered-fetch counter.
module inst_mem
    import inst_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic      clk,
    input  logic      rst,
    inst_mem_if.slave bus
);

    logic [AW-1:0]  w_word;
    logic           w_err;
    logic           w_we;
    logic           w_bypass;
    inst_bus_t      w_rdata;
    inst_bus_t      w_fetch_data;

    inst_bus_t      r_inst;
    inst_addr_bus_t r_inst_addr;
    logic           r_inst_valid;
    logic           r_addr_err;
    logic [31:0]    r_fetch_cnt;

    assign w_word = bus.addr[AW+1:2];
    assign w_err  = fetch_err(bus.addr, AW);
    // Loader is dead while reset is asserted; memory itself is never cleared.
    assign w_we   = bus.ld_we && (rst != RstEnable);

    inst_ram_1r1w #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (bus.ld_addr),
        .i_wdata (bus.ld_data),
        .i_raddr (w_word),
        .o_rdata (w_rdata)
    );

    assign w_bypass     = w_we && (bus.ld_addr == w_word);
    assign w_fetch_data = w_err ? Nop : (w_bypass ? bus.ld_data : w_rdata);

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            r_inst       <= Nop;
            r_inst_addr  <= '0;
            r_inst_valid <= 1'b0;
            r_addr_err   <= 1'b0;
            r_fetch_cnt  <= '0;
        end else if (!bus.stall) begin
            if (bus.ce == ChipDisable) begin
                r_inst       <= Nop;
                r_inst_valid <= 1'b0;
                r_addr_err   <= 1'b0;
            end else begin
                r_inst       <= w_fetch_data;
                r_inst_addr  <= bus.addr;
                r_inst_valid <= 1'b1;
                r_addr_err   <= w_err;
                r_fetch_cnt  <= r_fetch_cnt + 32'd1;
            end
        end
    end

    assign bus.inst       = r_inst;
    assign bus.inst_addr  = r_inst_addr;
    assign bus.inst_valid = r_inst_valid;
    assign bus.addr_err   = r_addr_err;
    assign bus.fetch_cnt  = r_fetch_cnt;

endmodule

// File: tb/tb_inst_mem.sv
// Directed plus randomized bench for inst_mem against a word-array reference model.
module tb_inst_mem;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    inst_mem_if #(.AW(AW)) bus ();

    inst_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] m_mem [DEPTH];
    logic [31:0] e_inst;
    logic [31:0] e_iaddr;
    logic        e_valid;
    logic        e_err;
    logic [31:0] e_cnt;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".inst"}, bus.inst, e_inst);
        chk({tag, ".inst_addr"}, bus.inst_addr, e_iaddr);
        chk({tag, ".inst_valid"}, {31'b0, bus.inst_valid}, {31'b0, e_valid});
        chk({tag, ".addr_err"}, {31'b0, bus.addr_err}, {31'b0, e_err});
        chk({tag, ".fetch_cnt"}, bus.fetch_cnt, e_cnt);
    endtask

    task automatic model_reset();
        e_inst  = 32'h0;
        e_iaddr = 32'h0;
        e_valid = 1'b0;
        e_err   = 1'b0;
        e_cnt   = 32'h0;
    endtask

    // Reference behaviour of one rising edge, computed from the byte address arithmetically.
    task automatic model_edge();
        int unsigned a;
        if (!rst) return;
        a = bus.addr;
        if (!bus.stall) begin
            if (bus.ce) begin
                if ((a % 4) != 0 || a >= DEPTH * 4) begin
                    e_inst = 32'h0;
                    e_err  = 1'b1;
                end else begin
                    e_inst = (bus.ld_we && int'(bus.ld_addr) == int'(a / 4)) ? bus.ld_data
                                                                             : m_mem[a / 4];
                    e_err  = 1'b0;
                end
                e_iaddr = a;
                e_valid = 1'b1;
                e_cnt   = e_cnt + 32'd1;
            end else begin
                e_inst  = 32'h0;
                e_valid = 1'b0;
                e_err   = 1'b0;
            end
        end
        if (bus.ld_we) m_mem[bus.ld_addr] = bus.ld_data;
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        bus.ce      = 1'b0;
        bus.stall   = 1'b0;
        bus.ld_we   = 1'b0;
        bus.addr    = 32'h0;
        bus.ld_addr = '0;
        bus.ld_data = 32'h0;
    endtask

    initial begin
        logic [31:0] prog [4];
        int unsigned sel;
        prog[0] = 32'h11; prog[1] = 32'h22; prog[2] = 32'h33; prog[3] = 32'h44;

        idle();
        model_reset();
        #2;
        check_all("reset");
        @(posedge clk);
        #1;
        check_all("reset_held");
        rst = 1'b1;

        // Fill the whole array so every later fetch has a known word.
        for (int i = 0; i < int'(DEPTH); i++) begin
            bus.ld_we   = 1'b1;
            bus.ld_addr = AW'(i);
            bus.ld_data = (i < 4) ? prog[i] : $urandom;
            cycle("preload");
        end
        bus.ld_we = 1'b0;

        // Sequential program fetch, one result per cycle.
        bus.ce = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.addr = 32'(4 * i);
            cycle("seq");
            chk("seq.lit", bus.inst, prog[i]);
        end
        chk("seq.cnt", bus.fetch_cnt, 32'd4);

        bus.addr = 32'h6;
        cycle("misalign");
        chk("misalign.err", {31'b0, bus.addr_err}, 32'd1);
        bus.addr = DEPTH * 4;
        cycle("oor");
        chk("oor.inst", bus.inst, 32'h0);
        chk("oor.err", {31'b0, bus.addr_err}, 32'd1);

        bus.addr = 32'h4;
        cycle("pre_stall");
        bus.stall = 1'b1;
        bus.addr  = 32'h8;
        for (int i = 0; i < 3; i++) cycle("stall");
        chk("stall.inst", bus.inst, 32'h22);
        chk("stall.iaddr", bus.inst_addr, 32'h4);
        chk("stall.cnt", bus.fetch_cnt, 32'd7);
        bus.stall = 1'b0;
        cycle("unstall");
        chk("unstall.inst", bus.inst, 32'h33);

        bus.ld_we   = 1'b1;
        bus.ld_addr = AW'(5);
        bus.ld_data = 32'hDEAD;
        bus.addr    = 32'd20;
        cycle("bypass");
        chk("bypass.lit", bus.inst, 32'hDEAD);
        bus.ld_we = 1'b0;

        bus.ce = 1'b0;
        for (int i = 0; i < 2; i++) cycle("ce_off");
        chk("ce_off.iaddr", bus.inst_addr, 32'd20);
        chk("ce_off.valid", {31'b0, bus.inst_valid}, 32'd0);

        // Reset asserted between edges; loader write during reset must be dropped.
        bus.ce   = 1'b1;
        bus.addr = 32'h0;
        cycle("pre_rst");
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        bus.ld_we   = 1'b1;
        bus.ld_addr = AW'(0);
        bus.ld_data = 32'hBAD0BAD0;
        cycle("rst_load");
        rst       = 1'b1;
        bus.ld_we = 1'b0;
        cycle("post_rst");
        chk("post_rst.lit", bus.inst, 32'h11);

        for (int i = 0; i < 300; i++) begin
            bus.ce      = ($urandom_range(0, 3) != 0);
            bus.stall   = ($urandom_range(0, 4) == 0);
            bus.ld_we   = ($urandom_range(0, 2) == 0);
            bus.ld_addr = AW'($urandom_range(0, DEPTH - 1));
            bus.ld_data = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0:       bus.addr = ($urandom_range(0, DEPTH * 4 - 1)) | 32'h1;
                1:       bus.addr = DEPTH * 4 + $urandom_range(0, 32'h7FFF_0000);
                2:       bus.addr = 32'(bus.ld_addr) * 4;
                default: bus.addr = $urandom_range(0, DEPTH - 1) * 4;
            endcase
            cycle("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
